fwft_pixel_unpacker: RTL
========================

// Module: fwft_pixel_unpacker
// PURPOSE
//  Read-side consumer of the FWFT COREFIFO wrapper in the camera-to-LCD path. Pops RWIDTH-bit
//  words from the FWFT FIFO. Splits each word into PIX_PER_WORD pixels of PIX_W bits.
//  Emits the pixels on a valid/ready stream with SOF/EOL/EOF markers for the LCD timing stage.
//  Tracks column/line position and flags FIFO underrun mid-frame.
// PARAMETERS
//  RWIDTH     32   FIFO read-word width; must be an integer multiple of PIX_W
//  PIX_W      16   pixel width (RGB565)
//  H_ACTIVE   640  pixels per line
//  V_ACTIVE   480  lines per frame
//  LSB_FIRST  1    1: pixel 0 = word[PIX_W-1:0]; 0: pixel 0 = word[RWIDTH-1:RWIDTH-PIX_W]
//  (local) PIX_PER_WORD = RWIDTH/PIX_W
// PORTS
//  rd_clk       in   1       read clock; all logic on the rising edge
//  aresetn_rclk in   1       asynchronous active-low reset
//  en           in   1       1: run; 0: finish the held word, then stop popping
//  fifo_empty   in   1       FWFT empty; fifo_dout is valid whenever this is 0
//  fifo_dout    in   RWIDTH  FWFT head word
//  fifo_rd_en   out  1       active-high pop; the head word is consumed on that edge
//  pix_data     out  PIX_W   current pixel
//  pix_valid    out  1       pix_data valid
//  pix_ready    in   1       sink accepts; transfer = pix_valid & pix_ready
//  pix_sof      out  1       qualified by pix_valid: pixel is col 0, line 0
//  pix_eol      out  1       qualified by pix_valid: pixel is col H_ACTIVE-1
//  pix_eof      out  1       qualified by pix_valid: pixel is last of the frame
//  col_cnt      out  16      column of the current pixel
//  line_cnt     out  16      line of the current pixel
//  frame_done   out  1       one-cycle pulse, the cycle after the EOF transfer
//  underrun     out  1       sticky; cleared by clr_err
//  clr_err      in   1       synchronous clear of underrun
// BEHAVIOUR
//  Reset values: all outputs 0 and state IDLE. This covers fifo_rd_en, pix_valid,
//    pix_data, all markers, both counters, frame_done and underrun.
//  Internal state:
//    wbuf[RWIDTH], the held word.
//    wvalid, set when wbuf holds a word.
//    sub[log2 PPW], the current pixel index within wbuf.
//  FSM states:
//    IDLE -> RUN when en=1.
//    RUN -> DRAIN when en=0 and wvalid=1.
//    RUN -> IDLE when en=0 and wvalid=0.
//    DRAIN -> IDLE when the last sub-pixel of wbuf transfers.
//    DRAIN never pops.
//  Pop rule (combinational): fifo_rd_en = state==RUN & en & !fifo_empty & (!wvalid | (xfer & sub==PPW-1)).
//  On a pop: wbuf<=fifo_dout, wvalid<=1, sub<=0 at the same edge. The first pixel is valid the next cycle.
//  Back-to-back words stream with no bubble. Sustained throughput is 1 pixel/clk when the FIFO is non-empty.
//  On a transfer:
//    If sub<PPW-1: sub increments.
//    If sub==PPW-1 and no pop: wvalid<=0.
//  pix_valid = wvalid. pix_data = slice sub of wbuf, ordered per LSB_FIRST. Both stay stable while pix_ready=0.
//  Counters advance only on a transfer:
//    col wraps H_ACTIVE-1 -> 0 and increments line.
//    line wraps V_ACTIVE-1 -> 0.
//  Words may straddle line boundaries; there is no realignment at EOL.
//  Markers are combinational from the counters and are meaningful only with pix_valid.
//  frame_done is registered: 1 for exactly one cycle after the EOF transfer.
//  Underrun: set when state==RUN & !wvalid & fifo_empty & pix_ready & (col!=0 | line!=0).
//    If clr_err and the set condition occur in the same cycle, set wins.
//  Stopping with en=0 does not reset the counters. The next frame continues from the held position.
//  Asserting reset mid-frame clears everything immediately, with no pop in that cycle.
// TESTING
//  1. RWIDTH=32, PIX_W=16, LSB_FIRST=1. FIFO holds 0xBBBBAAAA then 0xDDDDCCCC; ready=1.
//     -> pixels AAAA, BBBB, CCCC, DDDD on 4 consecutive clocks.
//     -> pops 2 cycles apart, no bubble.
//  2. Same data with LSB_FIRST=0 -> order BBBB, AAAA, DDDD, CCCC.
//  3. Toggle pix_ready 1,0,0,1 -> pix_data/pix_valid held during the stalls; no extra pop.
//  4. H=4, V=2 stream of 8 pixels.
//     -> sof on pixel 0.
//     -> eol on pixels 3 and 7; eof on pixel 7.
//     -> frame_done 1 cycle after pixel 7; counters return to 0,0.
//  5. fifo_empty=1 at col 2 with ready=1 -> underrun=1 and stays set.
//     -> clr_err clears it; empty at col 0, line 0 does not set it.
//  6. en drops with wbuf holding 2 pixels -> both delivered, no further pops, IDLE.
//     Reset asserted mid-word -> pix_valid=0 immediately.

Source files
------------

// File: rtl/fwft_pixel_unpacker_if.sv
// Bundles the FWFT FIFO read port and the pixel stream of the unpacker.
// master: the unpacker (pops the FIFO, drives the pixel stream).
// slave:  the environment (FIFO head word and the pixel sink).
interface fwft_pixel_unpacker_if #(
  parameter int RWIDTH = 32,
  parameter int PIX_W  = 16
);
  logic              fifo_empty;
  logic [RWIDTH-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eol;
  logic              pix_eof;
  logic [15:0]       col_cnt;
  logic [15:0]       line_cnt;

  modport master (
    input  fifo_empty, fifo_dout, pix_ready,
    output fifo_rd_en, pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
           col_cnt, line_cnt
  );

  modport slave (
    output fifo_empty, fifo_dout, pix_ready,
    input  fifo_rd_en, pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
           col_cnt, line_cnt
  );
endinterface

// File: rtl/fwft_pixel_unpacker.sv
// Pops words from an FWFT FIFO, splits them into pixels and streams them
// out with frame position markers; flags FIFO underrun inside a frame.
//
// state | meaning
// IDLE  | not popping; waiting for en
// RUN   | popping and streaming
// DRAIN | en dropped; finishing the held word without popping
module fwft_pixel_unpacker #(
  parameter int RWIDTH    = 32,
  parameter int PIX_W     = 16,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  rd_clk,
  input  logic                  aresetn_rclk,
  input  logic                  en,
  input  logic                  clr_err,
  output logic                  frame_done,
  output logic                  underrun,
  fwft_pixel_unpacker_if.master bus
);
  localparam int PPW   = RWIDTH / PIX_W;
  localparam int SUB_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PPW - 1);
  localparam logic [15:0] COL_LAST  = 16'(H_ACTIVE - 1);
  localparam logic [15:0] LINE_LAST = 16'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [RWIDTH-1:0] wbuf;
  logic              wvalid;
  logic [SUB_W-1:0]  sub;
  logic [15:0]       col_cnt, line_cnt;
  logic [PIX_W-1:0]  pix_sel;
  logic              xfer, last_sub, pop, col_last, line_last, set_under;

  assign xfer      = wvalid & bus.pix_ready;
  assign last_sub  = (sub == SUB_LAST);
  assign col_last  = (col_cnt == COL_LAST);
  assign line_last = (line_cnt == LINE_LAST);
  assign pop       = (state == RUN) & en & ~bus.fifo_empty &
                     (~wvalid | (xfer & last_sub));
  assign set_under = (state == RUN) & ~wvalid & bus.fifo_empty & bus.pix_ready &
                     ((col_cnt != 16'd0) | (line_cnt != 16'd0));

  // State register.
  always_ff @(posedge rd_clk or negedge aresetn_rclk) begin
    if (!aresetn_rclk) state <= IDLE;
    else               state <= state_nxt;
  end

  // Next-state logic; DRAIN also leaves if the word is already gone.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = wvalid ? DRAIN : IDLE;
      DRAIN:   if (!wvalid || (xfer && last_sub)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Held word and sub-pixel index; a pop restarts at sub-pixel 0.
  always_ff @(posedge rd_clk or negedge aresetn_rclk) begin
    if (!aresetn_rclk) begin
      wbuf   <= '0;
      wvalid <= 1'b0;
      sub    <= '0;
    end else if (pop) begin
      wbuf   <= bus.fifo_dout;
      wvalid <= 1'b1;
      sub    <= '0;
    end else if (xfer) begin
      if (!last_sub) sub    <= sub + SUB_W'(1);
      else           wvalid <= 1'b0;
    end
  end

  // Select the current sub-pixel in the configured order.
  always_comb begin
    pix_sel = '0;
    for (int i = 0; i < PPW; i++) begin
      if (sub == SUB_W'(i))
        pix_sel = LSB_FIRST ? wbuf[i*PIX_W +: PIX_W] : wbuf[(PPW-1-i)*PIX_W +: PIX_W];
    end
  end

  // Column/line position of the current pixel; words may straddle lines.
  always_ff @(posedge rd_clk or negedge aresetn_rclk) begin
    if (!aresetn_rclk) begin
      col_cnt  <= 16'd0;
      line_cnt <= 16'd0;
    end else if (xfer) begin
      if (col_last) begin
        col_cnt  <= 16'd0;
        line_cnt <= line_last ? 16'd0 : line_cnt + 16'd1;
      end else begin
        col_cnt <= col_cnt + 16'd1;
      end
    end
  end

  // One-cycle pulse after the last pixel of the frame transfers.
  always_ff @(posedge rd_clk or negedge aresetn_rclk) begin
    if (!aresetn_rclk) frame_done <= 1'b0;
    else               frame_done <= xfer & col_last & line_last;
  end

  // Sticky underrun; a new underrun outranks a clear in the same cycle.
  always_ff @(posedge rd_clk or negedge aresetn_rclk) begin
    if (!aresetn_rclk)  underrun <= 1'b0;
    else if (set_under) underrun <= 1'b1;
    else if (clr_err)   underrun <= 1'b0;
  end

  // Markers are gated with valid so they read 0 whenever no pixel is held.
  assign bus.fifo_rd_en = pop;
  assign bus.pix_valid  = wvalid;
  assign bus.pix_data   = pix_sel;
  assign bus.pix_sof    = wvalid & (col_cnt == 16'd0) & (line_cnt == 16'd0);
  assign bus.pix_eol    = wvalid & col_last;
  assign bus.pix_eof    = wvalid & col_last & line_last;
  assign bus.col_cnt    = col_cnt;
  assign bus.line_cnt   = line_cnt;
endmodule
